// File: rtl/mimo_frame_sequencer.sv
// -----------------------------------------------------------------------------
// mimo_frame_sequencer
//
// Buffers one frame from an upstream complex-sample stream and replays it to
// the x_calculate MIMO detector once per q session. A frame is 24 words:
// 0..15 = H[row][col] row-major, 16..19 = Y1[0..3], 20..23 = Y2[0..3].
// Each session opens with a one-cycle start_new_q. Then 16 H beats follow,
// with Y on the first 8 of them. The block then waits for det_done before the
// next q. After NUM_Q sessions it pulses frame_done and accepts a new frame.
//
// Optional feature macro: SEQ_TIMEOUT_EN
//   Adds a wait-state timeout of TIMEOUT cycles and the sticky timeout_err
//   output. Without the macro, the wait state waits indefinitely for det_done.
//
// Parameters
//   N        component width (two's complement, passed through unchanged)
//   NUM_Q    sessions per frame, 1..16
//   TIMEOUT  wait-state cycle limit (used only with SEQ_TIMEOUT_EN)
//
// Ports
//   clk, rst                 rising-edge clock, async active-high reset
//   in_valid/in_ready        upstream handshake; in_r/in_i sample words
//   start_new_q, q_index     session start pulse and current q
//   H_in_valid/H_in_r/H_in_i H word to the detector
//   Y_in_valid/Y_in_r/Y_in_i Y word to the detector (imag not conjugated)
//   det_done                 detector per-q completion pulse
//   frame_done               pulse after the last session of a frame
//   timeout_err              sticky timeout flag (SEQ_TIMEOUT_EN only)
//
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module mimo_frame_sequencer #(
  parameter int N       = 32,
  parameter int NUM_Q   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_r,
  input  logic [N-1:0] in_i,
  output logic         start_new_q,
  output logic [3:0]   q_index,
  output logic         H_in_valid,
  output logic [N-1:0] H_in_r,
  output logic [N-1:0] H_in_i,
  output logic         Y_in_valid,
  output logic [N-1:0] Y_in_r,
  output logic [N-1:0] Y_in_i,
  input  logic         det_done,
  output logic         frame_done
`ifdef SEQ_TIMEOUT_EN
  ,
  output logic         timeout_err
`endif
);

  if (NUM_Q < 1 || NUM_Q > 16 || TIMEOUT < 1) begin : g_bad_cfg
    $error("mimo_frame_sequencer: NUM_Q must be 1..16 and TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    S_FILL,
    S_START,
    S_STREAM,
    S_WAIT
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  wr_cnt, wr_nxt;
  logic [3:0]  rd_cnt, rd_nxt;
  logic [3:0]  q_cnt,  q_nxt;
  logic        accept;
  logic        advance;
  logic        last_q;

  logic [N-1:0] mem_r [24];
  logic [N-1:0] mem_i [24];

  assign accept = (state == S_FILL) && in_valid && in_ready;
  assign last_q = (q_cnt == 4'(NUM_Q - 1));

`ifdef SEQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wait_cnt;
  logic          timeout_hit;

  // A det_done in the timeout cycle itself wins: normal completion, no error.
  assign timeout_hit = (state == S_WAIT) && !det_done &&
                       (wait_cnt == WW'(TIMEOUT - 1));
  assign advance     = (state == S_WAIT) && (det_done || timeout_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_WAIT && !advance) wait_cnt <= wait_cnt + 1'b1;
      else                             wait_cnt <= '0;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign advance = (state == S_WAIT) && det_done;
`endif

  // NOTE: every signal written here gets its default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    wr_nxt    = wr_cnt;
    rd_nxt    = rd_cnt;
    q_nxt     = q_cnt;
    case (state)
      S_FILL: begin
        if (accept) begin
          if (wr_cnt == 5'd23) begin
            wr_nxt    = '0;
            q_nxt     = '0;
            state_nxt = S_START;
          end else begin
            wr_nxt = wr_cnt + 5'd1;
          end
        end
      end
      S_START: begin
        rd_nxt    = '0;
        state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (rd_cnt == 4'd15) state_nxt = S_WAIT;
        else                 rd_nxt    = rd_cnt + 4'd1;
      end
      S_WAIT: begin
        if (advance) begin
          if (last_q) begin
            state_nxt = S_FILL;
          end else begin
            q_nxt     = q_cnt + 4'd1;
            state_nxt = S_START;
          end
        end
      end
      default: state_nxt = S_FILL;
    endcase
  end

  // NOTE: the frame buffer has no reset; it is always fully rewritten by the
  // fill phase before any session reads it, so resetting it buys nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_r[wr_cnt] <= in_r;
      mem_i[wr_cnt] <= in_i;
    end
  end

  // Outputs are registered from the next-state view, so each output is valid
  // in the same cycle that the state register enters the matching state.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FILL;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      q_cnt       <= '0;
      in_ready    <= 1'b0;
      start_new_q <= 1'b0;
      H_in_valid  <= 1'b0;
      H_in_r      <= '0;
      H_in_i      <= '0;
      Y_in_valid  <= 1'b0;
      Y_in_r      <= '0;
      Y_in_i      <= '0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_cnt      <= wr_nxt;
      rd_cnt      <= rd_nxt;
      q_cnt       <= q_nxt;
      in_ready    <= (state_nxt == S_FILL);
      start_new_q <= (state_nxt == S_START);
      frame_done  <= advance && last_q;

      if (state_nxt == S_STREAM) begin
        H_in_valid <= 1'b1;
        H_in_r     <= mem_r[{1'b0, rd_nxt}];
        H_in_i     <= mem_i[{1'b0, rd_nxt}];
      end else begin
        H_in_valid <= 1'b0;
        H_in_r     <= '0;
        H_in_i     <= '0;
      end

      // Y rides along with the first 8 H beats, reading words 16..23.
      if (state_nxt == S_STREAM && !rd_nxt[3]) begin
        Y_in_valid <= 1'b1;
        Y_in_r     <= mem_r[{2'b10, rd_nxt[2:0]}];
        Y_in_i     <= mem_i[{2'b10, rd_nxt[2:0]}];
      end else begin
        Y_in_valid <= 1'b0;
        Y_in_r     <= '0;
        Y_in_i     <= '0;
      end
    end
  end

  assign q_index = q_cnt;

endmodule

// File: tb/tb_mimo_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mimo_frame_sequencer
//
// Self-checking bench for mimo_frame_sequencer. The stimulus side loads frames
// and plays the detector role (det_done). Whenever it issues an event with a
// predictable consequence, it pushes the expected outputs into scoreboard
// queues. Each entry holds a cycle stamp, the q and the data words, derived
// from the frame contents. A negedge monitor pops an entry whenever the DUT
// presents a start, an H/Y beat or a frame_done, and compares the two.
// With SEQ_TIMEOUT_EN defined, an extra frame runs without any det_done.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mimo_frame_sequencer;

  localparam int N     = 32;
  localparam int NUM_Q = 16;
  localparam int TO    = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_r = '0;
  logic [N-1:0] in_i = '0;
  logic         start_new_q;
  logic [3:0]   q_index;
  logic         H_in_valid;
  logic [N-1:0] H_in_r, H_in_i;
  logic         Y_in_valid;
  logic [N-1:0] Y_in_r, Y_in_i;
  logic         det_done = 1'b0;
  logic         frame_done;
`ifdef SEQ_TIMEOUT_EN
  logic         timeout_err;
`endif

  mimo_frame_sequencer #(.N(N), .NUM_Q(NUM_Q), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_r        (in_r),
    .in_i        (in_i),
    .start_new_q (start_new_q),
    .q_index     (q_index),
    .H_in_valid  (H_in_valid),
    .H_in_r      (H_in_r),
    .H_in_i      (H_in_i),
    .Y_in_valid  (Y_in_valid),
    .Y_in_r      (Y_in_r),
    .Y_in_i      (Y_in_i),
    .det_done    (det_done),
    .frame_done  (frame_done)
`ifdef SEQ_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  // Cycle number c is the interval between rising edge c and edge c+1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int           c;
    int           q;
    logic [N-1:0] r;
    logic [N-1:0] i;
  } ev_t;

  ev_t sq[$];
  ev_t hq[$];
  ev_t yq[$];
  int  fq[$];

  logic [N-1:0] fr_r [24];
  logic [N-1:0] fr_i [24];
  int           cur_s;

  // Reference model for one session starting at cycle s: start at s, H words
  // 0..15 on cycles s+1..s+16, and Y words 16..23 on cycles s+1..s+8.
  task automatic push_session(input int s, input int q);
    ev_t e;
    e.c = s; e.q = q; e.r = '0; e.i = '0;
    sq.push_back(e);
    for (int j = 0; j < 16; j++) begin
      e.c = s + 1 + j; e.r = fr_r[j]; e.i = fr_i[j];
      hq.push_back(e);
      if (j < 8) begin
        e.r = fr_r[16 + j]; e.i = fr_i[16 + j];
        yq.push_back(e);
      end
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  // Load one frame. pattern: word k = (k+1, -(k+1)); otherwise random.
  // toggle: in_valid alternates 1/0, with junk data on the idle cycles.
  task automatic load_frame(input bit pattern, input bit toggle);
    int bound;
    for (int k = 0; k < 24; k++) begin
      fr_r[k] = pattern ? N'(k + 1)    : N'($urandom);
      fr_i[k] = pattern ? N'(-(k + 1)) : N'($urandom);
    end
    for (int k = 0; k < 24; k++) begin
      if (toggle && k > 0) begin
        in_valid = 1'b0; in_r = N'($urandom); in_i = N'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1; in_r = fr_r[k]; in_i = fr_i[k];
      bound = 0;
      while (!in_ready && bound < 100) begin
        @(posedge clk); #1;
        bound++;
      end
      if (!in_ready) begin
        check("fill_in_ready_timeout", in_ready, 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_r = '0; in_i = '0;
    // The word-23 handshake edge was edge cyc, so start_new_q belongs to cycle cyc.
    cur_s = cyc;
    push_session(cur_s, 0);
  endtask

  // Play the detector for one frame. ign: extra det_done inside the stream.
  // abort_q: assert rst at stream beat 7 of that q. nodet: never send det_done.
  // fixed_k >= 0 fixes the extra wait cycles before det_done.
  task automatic run_frame(input bit ign, input int abort_q, input bit nodet, input int fixed_k);
    int s;
    int k;
    s = cur_s;
    for (int q = 0; q < NUM_Q; q++) begin
      k = (fixed_k >= 0) ? fixed_k : int'($urandom_range(0, 10));
      if (nodet) k = TO - 1;
      // Junk upstream traffic while busy must be ignored.
      wait_cyc(s + 2);
      in_valid = 1'b1; in_r = N'($urandom); in_i = N'($urandom);
      if (ign) begin
        wait_cyc(s + 5); det_done = 1'b1;
        wait_cyc(s + 6); det_done = 1'b0;
      end
      if (q == abort_q) begin
        wait_cyc(s + 8);
        in_valid = 1'b0;
        rst = 1'b1;
        sq.delete(); hq.delete(); yq.delete(); fq.delete();
        return;
      end
      wait_cyc(s + 10);
      in_valid = 1'b0;
      wait_cyc(s + 17 + k);
`ifdef SEQ_TIMEOUT_EN
      if (nodet && q == 0) check("timeout_err_early", timeout_err, 0);
`endif
      if (!nodet) det_done = 1'b1;
      if (q < NUM_Q - 1) push_session(s + 18 + k, q + 1);
      else               fq.push_back(s + 18 + k);
      wait_cyc(s + 18 + k);
      det_done = 1'b0;
`ifdef SEQ_TIMEOUT_EN
      if (nodet && q == 0) check("timeout_err_set", timeout_err, 1);
`endif
      s = s + 18 + k;
    end
    wait_cyc(s + 2);
  endtask

  ev_t me;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_ctrl_zero",
            {58'd0, start_new_q, H_in_valid, Y_in_valid, frame_done, in_ready, |q_index}, 0);
      check("rst_data_zero", {32'd0, H_in_r | H_in_i | Y_in_r | Y_in_i}, 0);
`ifdef SEQ_TIMEOUT_EN
      check("rst_timeout_err", timeout_err, 0);
`endif
    end else begin
      if (start_new_q) begin
        check("start_expected", sq.size() > 0, 1);
        if (sq.size() > 0) begin
          me = sq.pop_front();
          check("start_cycle", cyc, me.c);
          check("start_q_index", q_index, me.q);
        end
      end
      if (H_in_valid) begin
        check("h_expected", hq.size() > 0, 1);
        if (hq.size() > 0) begin
          me = hq.pop_front();
          check("h_cycle", cyc, me.c);
          check("h_q_index", q_index, me.q);
          check("h_r", H_in_r, me.r);
          check("h_i", H_in_i, me.i);
        end
      end else begin
        check("h_idle_data", H_in_r | H_in_i, 0);
      end
      if (Y_in_valid) begin
        check("y_expected", yq.size() > 0, 1);
        if (yq.size() > 0) begin
          me = yq.pop_front();
          check("y_cycle", cyc, me.c);
          check("y_r", Y_in_r, me.r);
          check("y_i", Y_in_i, me.i);
        end
      end else begin
        check("y_idle_data", Y_in_r | Y_in_i, 0);
      end
      if (frame_done) begin
        check("frame_done_expected", fq.size() > 0, 1);
        if (fq.size() > 0) check("frame_done_cycle", cyc, fq.pop_front());
        check("frame_done_in_ready", in_ready, 1);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_reset", in_ready, 1);
    check("q_index_after_reset", q_index, 0);

    // Counting pattern, back-to-back words, det_done 5 cycles after stream end.
    load_frame(1'b1, 1'b0);
    run_frame(1'b0, -1, 1'b0, 4);

    // Random frame with in_valid toggling every cycle, random wait lengths.
    load_frame(1'b0, 1'b1);
    run_frame(1'b0, -1, 1'b0, -1);

    // det_done pulsed during the stream must be ignored.
    load_frame(1'b0, 1'b0);
    run_frame(1'b1, -1, 1'b0, -1);

    // Reset at stream beat 7 of q 3, then a fresh frame from q 0.
    load_frame(1'b0, 1'b0);
    run_frame(1'b0, 3, 1'b0, -1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    load_frame(1'b0, 1'b0);
    run_frame(1'b0, -1, 1'b0, -1);

`ifdef SEQ_TIMEOUT_EN
    // No det_done at all: every session ends by timeout.
    load_frame(1'b0, 1'b0);
    run_frame(1'b0, -1, 1'b1, -1);
    check("timeout_err_sticky", timeout_err, 1);
`endif

    wait_cyc(cyc + 3);
    check("start_queue_drained", sq.size(), 0);
    check("h_queue_drained", hq.size(), 0);
    check("y_queue_drained", yq.size(), 0);
    check("frame_queue_drained", fq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mimo_frame_sequencer.md
# mimo_frame_sequencer

Feeds the `x_calculate` MIMO detector from an upstream complex-sample stream. It accepts one frame of channel matrix H (4x4 complex, row-major) and two receive vectors Y1/Y2 (4 complex each), and buffers the frame locally. It then replays the frame NUM_Q times, once per q_index, on the detector's start/H/Y load interface. Each replay waits for the detector's per-q completion pulse, or a timeout when that feature is compiled in, before starting the next q.

## Interface
- N, 32, sample width per real/imag component, two's-complement fixed point; passed through unchanged.
- NUM_Q, 16, number of q sessions per frame; q_index counts 0..NUM_Q-1; NUM_Q ≤ 16.
- TIMEOUT, 255, wait-state cycle limit; used only with SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  high when the block can accept a sample.
- in_r / in_i  in  N each  upstream sample; words 0..15 = H[row][col] row-major, 16..19 = Y1[0..3], 20..23 = Y2[0..3].
- start_new_q  out  1  one-cycle pulse that opens a detector session.
- q_index  out  4  current q; valid and stable from the start_new_q cycle through the end of that session's wait state.
- H_in_valid, H_in_r, H_in_i  out  1, N, N  H word to the detector.
- Y_in_valid, Y_in_r, Y_in_i  out  1, N, N  Y word to the detector.
- det_done  in  1  detector per-q completion pulse.
- frame_done  out  1  one-cycle pulse after the last q session completes.
- timeout_err  out  1  sticky error flag; exists only with SEQ_TIMEOUT_EN.

## Operation
- State machine: S_FILL → S_START → S_STREAM → S_WAIT → (S_START | S_FILL).
- **S_FILL**
  - in_ready = 1.
  - Each in_valid & in_ready handshake writes buf[wr_cnt] and increments wr_cnt (0..23).
  - Acceptance of word 23 clears wr_cnt, clears q_cnt, and moves to S_START.
- **S_START**
  - start_new_q = 1 and q_index = q_cnt for exactly one cycle.
  - Next state is S_STREAM.
- **S_STREAM** (rd_cnt 0..15, 16 cycles)
  - H_in_valid = 1 every cycle, with H_in_r/H_in_i = buf[rd_cnt].
  - Y_in_valid = 1 only for rd_cnt 0..7, with Y_in_r/Y_in_i = buf[16+rd_cnt].
  - Y imaginary parts are not negated; the detector conjugates them itself.
  - At rd_cnt = 15, move to S_WAIT.
- **S_WAIT**
  - On det_done: if q_cnt = NUM_Q-1, pulse frame_done and go to S_FILL; otherwise increment q_cnt and go to S_START.
- in_ready = 0 in every state except S_FILL; upstream must hold data until it is accepted.
- Whenever a valid output is low, its data outputs are driven to 0.
- All outputs are registered; no combinational path from any input to any output.

## Timing
- Reset values: in_ready 0 while rst is asserted, then 1 from the first cycle after release. All other outputs 0: start_new_q, q_index, H_in_valid, H_in_r, H_in_i, Y_in_valid, Y_in_r, Y_in_i, frame_done, timeout_err.
- Latency from the word-23 handshake edge:
  - start_new_q high in the following cycle.
  - First H_in_valid one cycle after start_new_q.
- Session length = 1 (start) + 16 (stream) + wait cycles. The minimum is 18 cycles, when det_done arrives in the first wait cycle.
- det_done asserted outside S_WAIT is ignored; it is not stored.
- The cycle that leaves S_WAIT→S_START has no outputs active. start_new_q is issued on the next cycle, which guarantees the detector's idle cycle between sessions.
- frame_done and the return of in_ready high occur in the same cycle.
- Reset mid-frame or mid-session:
  - Immediate return to S_FILL with wr_cnt, rd_cnt and q_cnt cleared.
  - Buffer contents are not cleared but are always overwritten before use.
  - A partially streamed session is abandoned.
- in_valid while in_ready = 0 has no effect.

## Configuration
- **SEQ_TIMEOUT_EN defined**
  - A wait counter runs in S_WAIT.
  - If det_done has not arrived after TIMEOUT cycles, set timeout_err (sticky until rst) and advance exactly as if det_done had arrived.
  - det_done arriving in the same cycle as the timeout counts as a normal completion; timeout_err is not set.
- **SEQ_TIMEOUT_EN undefined**
  - No counter and no timeout_err port.
  - S_WAIT waits indefinitely for det_done.

## Test plan
- Reset, then 24 back-to-back words valued k+1 (real) and -(k+1) (imag) → start_new_q one cycle after word 23 with q_index 0. Next 16 cycles: H_in_r = 1..16. First 8 of those cycles: Y_in_r = 17..24 and Y_in_i = -17..-24.
- det_done returned 5 cycles after each stream ends, NUM_Q=16 → q_index steps 0..15, each session has 16 H beats, exactly one frame_done after q 15, then in_ready = 1.
- Upstream in_valid toggled 1/0 every cycle → all 24 words are accepted in order, and S_START occurs only after the 24th handshake.
- det_done pulsed during S_STREAM and again in S_WAIT → the first pulse is ignored and the session advances only on the second.
- rst asserted at stream beat 7 of q 3, then a new frame loaded → all outputs 0 during reset; the new frame starts at q_index 0 with its new H data.
- With SEQ_TIMEOUT_EN and TIMEOUT=20, det_done never driven → timeout_err sets 20 cycles into the first S_WAIT, and all 16 sessions and frame_done still complete.
